// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings used by the writeback stage and the load-alignment logic.
package riscv_pkg;

    // Writeback source indices into the packed source array
    localparam int WB_LD  = 0;
    localparam int WB_ALU = 1;
    localparam int WB_PC4 = 2;
    localparam int WB_CSR = 3;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to writeback-stage bundle, including the register-file write port.
interface wb_stage_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          flush;
    logic [NUM_SRC-1:0][XLEN-1:0]  src_data;
    logic [SEL_W-1:0]              wb_sel;
    logic [2:0]                    ld_funct3;
    logic [1:0]                    ld_addr_lo;
    logic [4:0]                    rd_addr;
    logic                          rd_we;
    logic                          rf_ready;
    logic                          out_valid;
    logic                          rf_we;
    logic [4:0]                    rf_waddr;
    logic [XLEN-1:0]               rf_wdata;
    logic                          ld_misalign;

    // Upstream side: memory stage plus register-file readiness
    modport master (
        output in_valid, flush, src_data, wb_sel, ld_funct3, ld_addr_lo,
               rd_addr, rd_we, rf_ready,
        input  in_ready, out_valid, rf_we, rf_waddr, rf_wdata, ld_misalign
    );

    modport slave (
        input  in_valid, flush, src_data, wb_sel, ld_funct3, ld_addr_lo,
               rd_addr, rd_we, rf_ready,
        output in_ready, out_valid, rf_we, rf_waddr, rf_wdata, ld_misalign
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: byte/half/word extraction, sign/zero extension
// and misalignment detection. Also used by the cache-bypass path.
module load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;

    assign byte_v = raw_i[{addr_lo_i, 3'b000} +: 8];
    assign half_v = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    assign word_v = raw_i[31:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        data_o     = raw_i;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = XLEN'($signed(byte_v));
            F3_LBU: data_o = XLEN'(byte_v);
            F3_LH: begin
                misalign_o = addr_lo_i[0];
                data_o     = XLEN'($signed(half_v));
            end
            F3_LHU: begin
                misalign_o = addr_lo_i[0];
                data_o     = XLEN'(half_v);
            end
            F3_LW: begin
                misalign_o = (addr_lo_i != 2'd0);
                data_o     = XLEN'($signed(word_v));
            end
            default: data_o = raw_i;
        endcase
        // A misaligned access never exposes partial data downstream
        if (misalign_o) data_o = '0;
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: source select, load alignment, x0 suppression,
// back-pressure from the register-file port and flush.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int LD_SRC  = 0
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus
);
    wb_state_e       state_q, state_d;
    logic            full;
    logic            accept;

    logic            we_q, we_d;
    logic            mis_q, mis_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  sel_word;
    logic [XLEN-1:0]  la_data;
    logic             la_mis;
    logic             is_ld;
    logic [XLEN-1:0]  res_data;
    logic             res_mis;
    logic             res_we;

    assign full   = (state_q == WB_FULL);
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw_i      (bus.src_data[LD_SRC]),
        .funct3_i   (bus.ld_funct3),
        .addr_lo_i  (bus.ld_addr_lo),
        .data_o     (la_data),
        .misalign_o (la_mis)
    );

    // Result computation; out-of-range selects yield zero but still write
    always_comb begin
        sel      = bus.wb_sel;
        sel_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(sel) == i) sel_word = bus.src_data[i];
        end
        is_ld    = (int'(sel) == LD_SRC);
        res_data = is_ld ? la_data : sel_word;
        res_mis  = is_ld && la_mis;
        res_we   = bus.rd_we && (bus.rd_addr != 5'd0) && !res_mis;
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) state_q <= WB_EMPTY;
        else     state_q <= state_d;
    end

    // Next-state logic; rst is handled in the register, flush outranks accept
    always_comb begin
        state_d = state_q;
        if (bus.flush)         state_d = WB_EMPTY;
        else if (accept)       state_d = WB_FULL;
        else if (bus.rf_ready) state_d = WB_EMPTY;
    end

    // Output logic; in_ready is the only combinational output
    always_comb begin
        bus.out_valid = full;
        bus.in_ready  = !rst && (!full || bus.rf_ready);
    end

    // Datapath next values: hold by default
    always_comb begin
        we_d    = we_q;
        mis_d   = mis_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (bus.flush) begin
            we_d  = 1'b0;
            mis_d = 1'b0;
        end else if (accept) begin
            we_d    = res_we;
            mis_d   = res_mis;
            waddr_d = bus.rd_addr;
            wdata_d = res_data;
        end else if (full && bus.rf_ready) begin
            we_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            mis_q   <= mis_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.rf_we       = we_q;
    assign bus.ld_misalign = mis_q;
    assign bus.rf_waddr    = waddr_q;
    assign bus.rf_wdata    = wdata_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, parametrised writeback stage for the RISC-V core. It accepts one retiring instruction per cycle from the memory stage over a valid/ready handshake. It selects one of `NUM_SRC` result sources, aligns and sign- or zero-extends load data, and holds the result in an output register. That register drives the register-file write port and the forwarding network. It adds back-pressure from the register-file port, flush, misaligned-load detection and x0 suppression.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NUM_SRC`, 4, number of writeback sources. Must be ≥ 3.
- `SEL_W`, `$clog2(NUM_SRC)`, width of `wb_sel`. Derived; do not override.
- `LD_SRC`, 0, index of the load-data source. Only this source passes through load alignment.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept the instruction this cycle.
- `flush`  in  1  discard the held result and any incoming instruction.
- `src_data`  in  NUM_SRC×XLEN  packed source array. Default map: 0 load raw word, 1 ALU, 2 PC+4, 3 CSR.
- `wb_sel`  in  SEL_W  source index.
- `ld_funct3`  in  3  load type: LB, LH, LW, LBU, LHU.
- `ld_addr_lo`  in  2  byte offset of the load address.
- `rd_addr`  in  5  destination register.
- `rd_we`  in  1  instruction writes rd.
- `rf_ready`  in  1  register-file write port can accept the held result this cycle.
- `out_valid`  out  1  output register holds a result.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  write address.
- `rf_wdata`  out  XLEN  write data.
- `ld_misalign`  out  1  held instruction was a misaligned load.

## Operation
- Accept condition: `in_valid && in_ready && !flush`.
- `in_ready = !rst && (!out_valid || rf_ready)`. This allows full throughput when `rf_ready` stays high.
- On accept, the stage computes a result and loads it into the output register:
  - Source select: `wb_sel < NUM_SRC` selects `src_data[wb_sel]`. `wb_sel ≥ NUM_SRC` selects all-zeros; the write still occurs.
  - Load alignment, applied only when `wb_sel == LD_SRC`:
    - LB/LBU take the byte at `ld_addr_lo`.
    - LH/LHU take the halfword at `ld_addr_lo[1]`.
    - LW takes the whole word.
    - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
    - Any other funct3 passes the raw word.
  - Misalignment: LH/LHU with `ld_addr_lo[0]=1`, or LW with `ld_addr_lo≠0`, sets `ld_misalign=1`, `rf_we=0` and `rf_wdata=0`.
  - Write enable: `rf_we = rd_we && rd_addr != 0 && !misalign`.
- Hold: when `out_valid && !rf_ready`, every output keeps its value.
- Retire: when `out_valid && rf_ready` and nothing is accepted, the next state is `out_valid=0` and `rf_we=0`.
- Flush: next cycle `out_valid=0`, `rf_we=0`, `ld_misalign=0`. An instruction presented in the same cycle is dropped, even though `in_ready` may read 1.
- Effective state machine:
  - EMPTY → FULL on accept.
  - FULL → FULL on hold, or on accept while `rf_ready`.
  - FULL → EMPTY on `rf_ready` with no accept.
  - any → EMPTY on flush or rst.

## Timing
- Latency: exactly 1 cycle from accept to `out_valid`/`rf_we` asserted.
- Throughput: 1 instruction per cycle while `rf_ready=1`.
- Reset values: `out_valid=0`, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `ld_misalign=0`. `in_ready=0` while `rst` is high.
- Priority: `rst` > `flush` > accept > hold.
- Outputs are registered. `in_ready` is the only combinational output, and it depends on `rst`, `out_valid` and `rf_ready`.

## Structure
- Shared package `riscv_pkg` holds:
  - `wb_sel` encodings: `WB_LD=0`, `WB_ALU=1`, `WB_PC4=2`, `WB_CSR=3`.
  - load funct3 constants: `F3_LB=3'b000`, `F3_LH=3'b001`, `F3_LW=3'b010`, `F3_LBU=3'b100`, `F3_LHU=3'b101`.
- One combinational sub-module, `load_align`, takes raw word, funct3 and addr_lo and produces aligned data plus the misalign flag. It is reused by the future cache-bypass path.

## Test plan
- Mixed loads: raw `0x8899AABB`, LB @3 → `rf_wdata=0xFFFFFF88`. LBU @1 → `0x000000AA`. LH @2 → `0xFFFF8899`. LHU @0 → `0x0000AABB`. Each appears 1 cycle after accept.
- x0 and bad select: `wb_sel=1`, ALU `=0x12345678`, `rd_addr=0` → `rf_we=0`, `out_valid=1`, `rf_wdata=0x12345678`. `wb_sel=3` with `NUM_SRC=3` → `rf_wdata=0`, `rf_we=1`.
- Misaligned load: LW @2 → `ld_misalign=1`, `rf_we=0`, `rf_wdata=0`. LH @1 → same response.
- Back-pressure: hold `rf_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0`, outputs stable. `rf_ready=1` → the next instruction is loaded the same cycle, giving no bubble.
- Flush: `flush=1` with `out_valid=1` and `in_valid=1` → next cycle `out_valid=0`, `rf_we=0`, and the incoming instruction never appears.
- Reset mid-operation: assert `rst` while FULL with `rf_ready=0` → all outputs 0 next cycle and `in_ready=0` during reset. After release, the first accept gives the normal 1-cycle latency.
